// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions NUM_CH raw push-button inputs into clean, clk-synchronous events.
// Each channel is handled by its own independent slice:
//   1. A SYNC_STAGES-deep flop chain brings the asynchronous level into the
//      clk domain.
//   2. A debounce counter accepts a level change only after the synchronized
//      input has disagreed with the accepted level for DEBOUNCE_CYCLES
//      consecutive cycles.
//   3. Edge detection produces one-cycle press / release pulses.
//   4. A small hold state machine produces a one-cycle hold pulse after
//      HOLD_CYCLES of continuous press, then every REPEAT_CYCLES after that
//      (REPEAT_CYCLES = 0 gives a single hold pulse per press).
//
// Parameters
//   NUM_CH          number of channels (1..16)
//   SYNC_STAGES     synchronizer depth (2..4)
//   DEBOUNCE_CYCLES stable cycles needed to accept a change (>= 1)
//   HOLD_CYCLES     press duration before the first hold pulse (>= 1)
//   REPEAT_CYCLES   spacing of auto-repeat hold pulses, 0 = no repeat
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   btn_in       raw button levels, 1 = pressed
//   btn_level    debounced level (registered)
//   btn_press    one-cycle pulse when btn_level rises
//   btn_release  one-cycle pulse when btn_level falls
//   btn_hold     one-cycle pulse on long press and on each repeat interval
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int NUM_CH          = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_hold
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("button_conditioner: NUM_CH must be in 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_conditioner: HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 0) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_CYCLES must be >= 0");
  end

  // ---------------------------------------------------------------------------
  // Counter sizing. Counters only ever hold 0..terminal-1 (they clear instead
  // of reaching the terminal value), so $clog2(terminal) bits are enough;
  // a floor of one bit keeps the degenerate terminal = 1 case legal.
  // ---------------------------------------------------------------------------
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // The hold counter is shared between the initial hold wait and the repeat
  // interval, so it is sized for the larger of the two.
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;

  // Terminal compare values (last count before the event fires).
  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_TERM = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_TERM  = HC_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  localparam bit              REP_EN    = (REPEAT_CYCLES > 0);

  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
  localparam logic [HC_W-1:0] HC_ONE = HC_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } hold_state_t;

  // ---------------------------------------------------------------------------
  // Per-channel slices
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch

      logic [SYNC_STAGES-1:0] sync_reg;
      logic [DB_W-1:0]        db_cnt_reg;
      logic                   level_reg;
      logic                   press_reg;
      logic                   release_reg;
      logic                   hold_reg;
      logic [HC_W-1:0]        hold_cnt_reg;
      hold_state_t            state_reg;

      logic                   sync_bit;
      logic                   differ;
      logic                   db_done;
      logic                   level_next;

      assign sync_bit = sync_reg[SYNC_STAGES-1];
      assign differ   = sync_bit ^ level_reg;
      // Accept the new level on the edge where the counter would otherwise
      // step past its terminal value.
      assign db_done    = differ && (db_cnt_reg == DB_TERM);
      assign level_next = db_done ? sync_bit : level_reg;

      // -----------------------------------------------------------------------
      // Synchronizer, debounce and edge pulses
      // -----------------------------------------------------------------------
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg    <= '0;
          db_cnt_reg  <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_in[gi]};

          // Any agreeing cycle restarts the stability window; acceptance
          // also restarts it so the next change needs a full window again.
          if (!differ || db_done) begin
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_ONE;
          end

          level_reg   <= level_next;
          press_reg   <= level_next & ~level_reg;
          release_reg <= ~level_next & level_reg;
        end
      end

      // -----------------------------------------------------------------------
      // Hold / auto-repeat state machine.
      // Decisions look at level_next so that a release landing on the same
      // edge as a hold terminal count wins: the channel drops to IDLE and no
      // hold pulse is emitted alongside the release pulse.
      // -----------------------------------------------------------------------
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg    <= IDLE;
          hold_cnt_reg <= '0;
          hold_reg     <= 1'b0;
        end else begin
          hold_reg <= 1'b0;
          case (state_reg)
            IDLE: begin
              hold_cnt_reg <= '0;
              if (level_next) begin
                state_reg <= WAIT_HOLD;
              end
            end

            WAIT_HOLD: begin
              if (!level_next) begin
                state_reg    <= IDLE;
                hold_cnt_reg <= '0;
              end else if (hold_cnt_reg == HOLD_TERM) begin
                state_reg    <= REPEAT;
                hold_cnt_reg <= '0;
                hold_reg     <= 1'b1;
              end else begin
                hold_cnt_reg <= hold_cnt_reg + HC_ONE;
              end
            end

            REPEAT: begin
              if (!level_next) begin
                state_reg    <= IDLE;
                hold_cnt_reg <= '0;
              end else if (!REP_EN) begin
                // Repeat disabled: park here silently until release.
                hold_cnt_reg <= '0;
              end else if (hold_cnt_reg == REP_TERM) begin
                hold_cnt_reg <= '0;
                hold_reg     <= 1'b1;
              end else begin
                hold_cnt_reg <= hold_cnt_reg + HC_ONE;
              end
            end

            default: begin
              state_reg    <= IDLE;
              hold_cnt_reg <= '0;
            end
          endcase
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_hold[gi]    = hold_reg;

    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with NUM_CH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5. Outputs are sampled 1 ns
// after each rising edge and compared, packed as
// {btn_level, btn_press, btn_release, btn_hold}, against hand-derived values.
// Edge numbering: edge 1 is the first rising edge that samples a new btn_in.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NUM_CH          = 2;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int HOLD_CYCLES     = 10;
  localparam int REPEAT_CYCLES   = 5;

  logic              clk;
  logic              clk_en;
  logic              reset;
  logic [NUM_CH-1:0] btn_in;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] btn_press;
  logic [NUM_CH-1:0] btn_release;
  logic [NUM_CH-1:0] btn_hold;
  logic [7:0]        obs;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NUM_CH          (NUM_CH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold)
  );

  assign obs = {btn_level, btn_press, btn_release, btn_hold};

  // Clock stays low until clk_en so the asynchronous reset can be observed
  // with no edges at all.
  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ev(input logic [1:0] l, input logic [1:0] p,
                                    input logic [1:0] r, input logic [1:0] h);
    return {l, p, r, h};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got lvl/prs/rel/hld=%b required=%b", tag, got, exp);
    end else begin
      $display("ok   %s lvl/prs/rel/hld=%b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [7:0] exp);
    tick();
    check(tag, obs, exp);
  endtask

  initial begin
    logic [15:0] pat;
    logic [1:0]  l, p, r, h;

    clk_en = 1'b0;
    reset  = 1'b0;
    btn_in = 2'b11;

    // ---------------- Reset with no clock, then release with buttons held
    #2 reset = 1'b1;
    #3 check("rst_async_noclk", obs, 8'h00);
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("rst_held e%0d", i), 8'h00);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) cyc($sformatf("A e%0d", e), 8'h00);
    cyc("A e6 press11", ev(2'b11, 2'b11, 2'b00, 2'b00));
    cyc("A e7", ev(2'b11, 2'b00, 2'b00, 2'b00));
    btn_in = 2'b00;
    for (int e = 1; e <= 5; e++) cyc($sformatf("A rel e%0d", e), ev(2'b11, 2'b00, 2'b00, 2'b00));
    cyc("A rel e6 release11", ev(2'b00, 2'b00, 2'b11, 2'b00));
    for (int e = 7; e <= 12; e++) cyc($sformatf("A quiet e%0d", e), 8'h00);

    // ---------------- Ch0 press, hold/repeat, release on a repeat terminal
    btn_in = 2'b01;
    for (int e = 1; e <= 5; e++) cyc($sformatf("B e%0d", e), 8'h00);
    cyc("B e6 press01", ev(2'b01, 2'b01, 2'b00, 2'b00));
    // Press at P; holds due at P+10,15,...,40; release input after P+39
    // makes the level fall at P+45, which is also a repeat terminal.
    for (int c = 1; c <= 45; c++) begin
      if (c == 40) btn_in = 2'b00;
      l = {1'b0, (c < 45)};
      r = {1'b0, (c == 45)};
      h = {1'b0, (c >= 10 && ((c - 10) % 5) == 0 && c < 45)};
      cyc($sformatf("B P+%0d", c), ev(l, 2'b00, r, h));
    end
    for (int c = 46; c <= 56; c++) cyc($sformatf("B quiet P+%0d", c), 8'h00);

    // ---------------- Short excursion and bounce on ch0: no effect
    pat = 16'b0000_0000_0101_0111;  // LSB first: 1,1,1,0,1,0,1,0,0...
    for (int i = 0; i < 16; i++) begin
      btn_in = {1'b0, pat[i]};
      cyc($sformatf("C bounce i%0d", i), 8'h00);
    end

    // ---------------- Ch1 pulse of exactly DEBOUNCE_CYCLES is accepted
    btn_in = 2'b10;
    for (int e = 1; e <= 4; e++) begin
      if (e == 5) btn_in = 2'b00;
      cyc($sformatf("C4 e%0d", e), 8'h00);
    end
    btn_in = 2'b00;
    cyc("C4 e5", 8'h00);
    cyc("C4 e6 press10", ev(2'b10, 2'b10, 2'b00, 2'b00));
    for (int e = 7; e <= 9; e++) cyc($sformatf("C4 e%0d", e), ev(2'b10, 2'b00, 2'b00, 2'b00));
    cyc("C4 e10 release10", ev(2'b00, 2'b00, 2'b10, 2'b00));
    for (int e = 11; e <= 20; e++) cyc($sformatf("C4 quiet e%0d", e), 8'h00);

    // ---------------- Both channels together, ch1 released first
    btn_in = 2'b11;
    for (int e = 1; e <= 5; e++) cyc($sformatf("D e%0d", e), 8'h00);
    cyc("D e6 press11", ev(2'b11, 2'b11, 2'b00, 2'b00));
    for (int c = 1; c <= 33; c++) begin
      if (c == 13) btn_in = 2'b01;  // ch1 level falls at P+18
      if (c == 28) btn_in = 2'b00;  // ch0 level falls at P+33
      l = {(c < 18), (c < 33)};
      r = {(c == 18), (c == 33)};
      h = {(c >= 10 && ((c - 10) % 5) == 0 && c < 18),
           (c >= 10 && ((c - 10) % 5) == 0 && c < 33)};
      cyc($sformatf("D P+%0d", c), ev(l, 2'b00, r, h));
    end
    for (int c = 34; c <= 41; c++) cyc($sformatf("D quiet P+%0d", c), 8'h00);

    // ---------------- Reset during the hold wait discards the pending hold
    btn_in = 2'b01;
    for (int e = 1; e <= 5; e++) cyc($sformatf("E e%0d", e), 8'h00);
    cyc("E e6 press01", ev(2'b01, 2'b01, 2'b00, 2'b00));
    for (int c = 1; c <= 6; c++) cyc($sformatf("E P+%0d", c), ev(2'b01, 2'b00, 2'b00, 2'b00));
    reset = 1'b1;
    #1 check("E rst_async", obs, 8'h00);
    cyc("E rst P+7", 8'h00);
    cyc("E rst P+8", 8'h00);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) cyc($sformatf("E post e%0d", e), 8'h00);
    cyc("E post e6 press01", ev(2'b01, 2'b01, 2'b00, 2'b00));
    for (int c = 1; c <= 10; c++) begin
      p = 2'b00;
      h = {1'b0, (c == 10)};
      cyc($sformatf("E Q+%0d", c), ev(2'b01, p, 2'b00, h));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_CH, default 5: number of independent push-button channels, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 100000: consecutive stable clk cycles required to accept a level change, legal minimum 1.
REQ-004 Parameter HOLD_CYCLES, default 100000000: clk cycles of continuous debounced press before the first hold pulse, legal minimum 1.
REQ-005 Parameter REPEAT_CYCLES, default 25000000: clk cycles between auto-repeat hold pulses after the first; 0 disables repeat.
REQ-006 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 btn_in  input  NUM_CH  raw asynchronous button levels, 1 = pressed.
REQ-009 btn_level  output  NUM_CH  registered debounced level per channel.
REQ-010 btn_press  output  NUM_CH  one-cycle pulse on each debounced 0->1 transition.
REQ-011 btn_release  output  NUM_CH  one-cycle pulse on each debounced 1->0 transition.
REQ-012 btn_hold  output  NUM_CH  one-cycle pulse on long press and on each auto-repeat interval.

Function
REQ-013 Each channel SHALL pass btn_in through a SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-014 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-015 Debounce per channel: counter cleared on any cycle where sync[i] == btn_level[i]; incremented on each cycle where they differ.
REQ-016 When the counter already equals DEBOUNCE_CYCLES-1 and sync[i] still differs, btn_level[i] SHALL take sync[i] and the counter SHALL clear on the same edge.
REQ-017 Latency: a clean step on btn_in held indefinitely SHALL appear on btn_level exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-018 Any sync[i] excursion shorter than DEBOUNCE_CYCLES cycles SHALL leave btn_level[i] and all pulses unchanged.
REQ-019 btn_press[i] / btn_release[i] SHALL be high in exactly the cycle btn_level[i] has just risen / fallen; never both high together.
REQ-020 Hold counter per channel SHALL clear while btn_level[i] is 0 and count each cycle while btn_level[i] is 1.
REQ-021 Hold state machine per channel: IDLE (level 0) -> WAIT_HOLD on press; WAIT_HOLD -> REPEAT after HOLD_CYCLES cycles with level 1, emitting btn_hold; REPEAT emits btn_hold every REPEAT_CYCLES cycles, counter reloading on each pulse; any state -> IDLE on release.
REQ-022 First btn_hold[i] SHALL assert HOLD_CYCLES edges after the btn_press[i] cycle; with REPEAT_CYCLES=0 REPEAT SHALL remain silent until release.
REQ-023 Counter widths SHALL be derived by $clog2 so no counter wraps at its terminal value; counters SHALL never increment beyond terminal.
REQ-024 Release coinciding with a hold terminal count: btn_release SHALL assert and btn_hold SHALL NOT.

Reset
REQ-025 While reset is high, all synchronizer flops, debounce counters, hold counters and state SHALL be 0 / IDLE and btn_level, btn_press, btn_release, btn_hold SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the pending change; after release the channel SHALL restart from level 0 with no spurious pulse, even if btn_in is 1.

Verification (NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5)
REQ-027 Assert reset with btn_in=2'b11, no clk -> all outputs 0 immediately; deassert with btn_in=11 -> btn_level=11 and btn_press=11 for one cycle, 6 edges later.
REQ-028 btn_in[0] 0->1 held -> btn_level[0]=1 on edge 6, btn_press[0] high for one cycle, btn_in[1] channel quiet.
REQ-029 btn_in[0] pulse of 3 cycles, then bounce 1-0-1-0 each one cycle -> btn_level[0] stays 0, no pulses.
REQ-030 Hold btn_in[0] for 40 cycles after press -> btn_hold[0] at press+10, +15, +20, +25, ...; release -> btn_release[0] 6 edges after btn_in falls, no further btn_hold.
REQ-031 Press both channels on the same cycle -> btn_press=11 in one cycle; release ch1 only -> btn_release=10 (ch1 bit), ch0 hold pulses continue on schedule.
REQ-032 Reset pulse 2 cycles wide at press+7 during hold wait -> outputs 0; no btn_hold at press+10; btn_in still 1 -> new btn_press 6 edges after reset release.
